pipelined_rippleadder: RTL and testbench

4-bit ripple-carry adder with registers only at its boundary: A, B and cin are captured in an input register stage, summed combinationally through four chained full adders, and the result (S, cout) is captured in an output register stage. It is a small datapath leaf used where registered I/O timing is required around a ripple adder. Throughput is one addition per clock, and latency is fixed at two clocks.

---
 rtl/pipelined_rippleadder_pkg.sv | 4 +
 rtl/pipelined_rippleadder_full_adder.sv | 14 +
 rtl/pipelined_rippleadder.sv | 60 ++++++
 tb/tb_pipelined_rippleadder.sv | 116 +++++++++++
 4 files changed

// File: rtl/pipelined_rippleadder_pkg.sv
// Shared constants for the registered 4-bit ripple-carry adder.
package pipelined_rippleadder_pkg;
    localparam int ADDER_WIDTH = 4;
endpackage

// File: rtl/pipelined_rippleadder_full_adder.sv
// One-bit full adder cell, purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);
endmodule

// File: rtl/pipelined_rippleadder.sv
// Ripple-carry adder with an input register stage and an output register stage (2-clock latency).
module pipelined_rippleadder
    import pipelined_rippleadder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDER_WIDTH-1:0] A,
    input  logic [ADDER_WIDTH-1:0] B,
    input  logic                   cin,
    output logic [ADDER_WIDTH-1:0] S,
    output logic                   cout
);
    logic [ADDER_WIDTH-1:0] a_reg;
    logic [ADDER_WIDTH-1:0] b_reg;
    logic                   cin_reg;
    logic [ADDER_WIDTH-1:0] s_reg;
    logic                   cout_reg;

    logic [ADDER_WIDTH:0]   carry;
    logic [ADDER_WIDTH-1:0] sum_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            cin_reg <= 1'b0;
        end else begin
            a_reg   <= A;
            b_reg   <= B;
            cin_reg <= cin;
        end
    end

    assign carry[0] = cin_reg;

    generate
        for (genvar gi = 0; gi < ADDER_WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a  (a_reg[gi]),
                .b  (b_reg[gi]),
                .ci (carry[gi]),
                .s  (sum_next[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_reg    <= '0;
            cout_reg <= 1'b0;
        end else begin
            s_reg    <= sum_next;
            cout_reg <= carry[ADDER_WIDTH];
        end
    end

    assign S    = s_reg;
    assign cout = cout_reg;
endmodule

// File: tb/tb_pipelined_rippleadder.sv
// Directed and streaming bench for the registered ripple adder.
module tb_pipelined_rippleadder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] A   = 4'd15;
    logic [3:0] B   = 4'd15;
    logic       cin = 1'b1;
    logic [3:0] S;
    logic       cout;

    int checks   = 0;
    int failures = 0;

    // Reference of the two register stages, holding full 5-bit sums.
    logic [4:0] m_in  = 5'd0;
    logic [4:0] m_out = 5'd0;

    pipelined_rippleadder dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .cin  (cin),
        .S    (S),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (!rst) begin
            m_out = 5'd0;
            m_in  = 5'd0;
        end else begin
            m_out = m_in;
            m_in  = {1'b0, A} + {1'b0, B} + {4'b0, cin};
        end
        checks++;
        assert ({cout, S} === m_out) else begin
            failures++;
            $error("FAIL %s model got=%b expected=%b", tag, {cout, S}, m_out);
        end
        $display("step %s A=%0d B=%0d cin=%0d rst=%0d -> cout=%0d S=%b", tag, A, B, cin, rst, cout, S);
    endtask

    task automatic check_hand(input string tag, input logic [4:0] exp);
        checks++;
        assert ({cout, S} === exp) else begin
            failures++;
            $error("FAIL %s got=%b expected=%b", tag, {cout, S}, exp);
        end
    endtask

    logic [3:0] dir_a [8] = '{4'd1, 4'd5,  4'd6, 4'd6, 4'd4, 4'd15, 4'd8, 4'd0};
    logic [3:0] dir_b [8] = '{4'd9, 4'd10, 4'd3, 4'd3, 4'd7, 4'd0,  4'd8, 4'd0};
    logic       dir_c [8] = '{1'b0, 1'b1,  1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0};
    logic [4:0] dir_e [8] = '{5'b01010, 5'b10000, 5'b01001, 5'b01010,
                              5'b01100, 5'b10000, 5'b10000, 5'b00000};

    initial begin
        // Reset held for 5 edges with all-ones inputs.
        for (int i = 0; i < 5; i++) begin
            tick("reset_hold");
            check_hand("reset_hold_zero", 5'd0);
        end
        rst = 1'b1;
        tick("release_first");
        check_hand("release_first_zero", 5'd0);
        tick("release_second");
        check_hand("release_max_31", 5'b11111);

        // Directed sums and carry ripple cases, back to back.
        for (int i = 0; i < 8; i++) begin
            A = dir_a[i]; B = dir_b[i]; cin = dir_c[i];
            tick("directed");
            if (i > 0) check_hand($sformatf("directed_%0d", i - 1), dir_e[i - 1]);
        end
        tick("directed_tail");
        check_hand("directed_7", dir_e[7]);

        // Random streaming with no bubbles.
        for (int i = 0; i < 32; i++) begin
            A = 4'($urandom_range(0, 15)); B = 4'($urandom_range(0, 15)); cin = 1'($urandom_range(0, 1));
            tick("stream");
        end

        // One-edge reset while results are in flight.
        rst = 1'b0;
        A = 4'd9; B = 4'd9; cin = 1'b1;
        tick("midreset_edge");
        check_hand("midreset_zero_0", 5'd0);
        rst = 1'b1;
        A = 4'd3; B = 4'd12; cin = 1'b0;
        tick("midreset_release");
        check_hand("midreset_zero_1", 5'd0);
        A = 4'd7; B = 4'd8; cin = 1'b1;
        tick("midreset_resume");
        check_hand("midreset_resume_15", 5'b01111);
        tick("midreset_resume2");
        check_hand("midreset_resume_16", 5'b10000);

        // Exhaustive sweep at full rate.
        for (int v = 0; v < 512; v++) begin
            A = v[3:0]; B = v[7:4]; cin = v[8];
            tick("exhaustive");
        end
        tick("flush0");
        tick("flush1");
        check_hand("flush_last_31", 5'b11111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
